// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers row/col/valid from sampled HSYNC/VSYNC, qualified by a lock FSM
module vga_sync_decoder #(
  parameter int H_ACTIVE        = 640,
  parameter int H_TOTAL         = 800,
  parameter int H_SYNC_START    = 656,
  parameter int V_ACTIVE        = 480,
  parameter int V_TOTAL         = 525,
  parameter int V_SYNC_START    = 490,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_LINES      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       valid,
  output logic       locked,
  output logic       frame_start,
  output logic [7:0] err_count
);
  localparam logic IDLE = SYNC_ACTIVE_LOW != 0;
  localparam int GW = $clog2(LOCK_LINES + 1);
  localparam logic [9:0] H_RELOAD = 10'((H_SYNC_START + 1) % H_TOTAL);
  typedef enum logic [1:0] {SEARCH, H_ACQ, V_ACQ, LOCKED} state_t;
  state_t state, state_n;
  logic [1:0] hs_s, vs_s;
  logic hs_p, vs_p, h_edge, v_edge, good, timeout, lose, col_wrap;
  logic [10:0] per;
  logic [GW-1:0] good_cnt, good_cnt_n;
  assign col_wrap = col == 10'(H_TOTAL - 1);
  assign good = per == 11'(H_TOTAL - 1);
  assign timeout = !h_edge && per >= 11'(2 * H_TOTAL - 1);
  assign locked = state == LOCKED;
  assign valid = locked && row < 10'(V_ACTIVE) && col < 10'(H_ACTIVE);
  assign frame_start = locked && row == 10'd0 && col == 10'd0;
  // The edge pulse is registered so the cycle it is high lines up with col==H_SYNC_START.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hs_s <= {2{IDLE}};
      vs_s <= {2{IDLE}};
      hs_p <= IDLE;
      vs_p <= IDLE;
      h_edge <= 1'b0;
      v_edge <= 1'b0;
    end else begin
      hs_s <= {hs_s[0], hsync_in};
      vs_s <= {vs_s[0], vsync_in};
      hs_p <= hs_s[1];
      vs_p <= vs_s[1];
      h_edge <= (hs_s[1] ^ IDLE) & ~(hs_p ^ IDLE);
      v_edge <= (vs_s[1] ^ IDLE) & ~(vs_p ^ IDLE);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      row <= '0;
      per <= '0;
      state <= SEARCH;
      good_cnt <= '0;
      err_count <= '0;
    end else begin
      col <= h_edge ? H_RELOAD : col_wrap ? 10'd0 : col + 10'd1;
      row <= v_edge ? 10'(V_SYNC_START) :
             col_wrap && !h_edge ? (row == 10'(V_TOTAL - 1) ? 10'd0 : row + 10'd1) : row;
      per <= h_edge ? 11'd0 : &per ? per : per + 11'd1;
      state <= state_n;
      good_cnt <= good_cnt_n;
      err_count <= lose && err_count != 8'hff ? err_count + 8'd1 : err_count;
    end
  always_comb begin
    state_n = state;
    good_cnt_n = good_cnt;
    lose = 1'b0;
    case (state)
      SEARCH: if (h_edge) begin
        state_n = H_ACQ;
        good_cnt_n = '0;
      end
      H_ACQ: if (h_edge) begin
        good_cnt_n = good ? good_cnt + GW'(1) : '0;
        if (good && good_cnt == GW'(LOCK_LINES - 1)) state_n = V_ACQ;
      end
      V_ACQ: state_n = h_edge && !good ? SEARCH : v_edge ? LOCKED : V_ACQ;
      default: begin
        lose = (h_edge && (!good || col != 10'(H_SYNC_START))) ||
               (v_edge && row != 10'(V_SYNC_START));
        state_n = lose ? SEARCH : LOCKED;
      end
    endcase
    if (timeout && state != SEARCH) begin
      state_n = SEARCH;
      lose = state == LOCKED;
    end
  end
endmodule
